mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the word-wide data cache.
- Accepts one byte/half/word load or store request at a time from the execute stage.
- Checks alignment and issues whole-word cache reads and writes; sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data, or an error flag, to the writeback stage.

Parameters:
- ADDR_W, 32, byte address width; equals system address space width.
- READ_SWAP, 1, when 1 byte-reverse cache_rdata_i before use. The cache read port returns address offset 0 in bits [31:24]; its write port takes offset 0 in bits [7:0].

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  unit can accept a request this cycle
- req_we_i  input  1  1 = store, 0 = load
- req_addr_i  input  ADDR_W  byte address
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  input  1  zero-extend load result (LBU/LHU)
- req_wdata_i  input  32  store data, right-justified
- rsp_valid_o  output  1  one-cycle response pulse
- rsp_rdata_o  output  32  load result; 0 for stores and errors
- rsp_err_o  output  1  misaligned or illegal size; qualified by rsp_valid_o
- cache_re_o  output  1  cache read enable
- cache_r_addr_o  output  ADDR_W  cache read address
- cache_rdata_i  input  32  cache read data; combinational, valid in the same cycle as re
- cache_we_o  output  1  cache write enable
- cache_w_addr_o  output  ADDR_W  cache write address
- cache_w_data_o  output  32  cache write word; lane k = bits [8k+7:8k] = byte offset k

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- req_ready_o = 1 only in IDLE. A request is accepted on a clock edge with req_valid_i & req_ready_o. All request fields are registered at acceptance.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0.
  - A misaligned request or size 11 goes IDLE->RESP with rsp_err_o=1 and rsp_rdata_o=0, with no cache access.
- Load: IDLE->READ->RESP.
  - In READ: cache_re_o=1 and cache_r_addr_o = registered address. The word (swapped per READ_SWAP) is captured at the end of the cycle.
  - Latency: the response arrives 2 cycles after acceptance.
- Word store: IDLE->WRITE->RESP.
  - In WRITE: cache_we_o=1, cache_w_addr_o = address, cache_w_data_o = req_wdata.
- Byte/half store: IDLE->READ->WRITE->RESP.
  - The READ word is captured.
  - Byte: lane addr[1:0] is replaced by wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} are replaced by wdata[15:0].
  - Other lanes are unchanged. The merged word is written in WRITE.
- Load extraction:
  - Byte uses lane addr[1:0]; half uses lanes addr[1]*2 (low) and addr[1]*2+1 (high); word uses the whole word.
  - Sign-extend from bit 7/15 unless req_unsigned_i=1. req_unsigned_i is ignored for word loads.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then return to IDLE.
  - There is no response back-pressure; the consumer must take it.
  - The next request can be accepted in the cycle after RESP.
- Cache enables are decoded from state only. re and we are never both 1. Both are 0 in IDLE and RESP.
- Inactive addresses and data drive 0: cache_r_addr_o when re=0; cache_w_addr_o and cache_w_data_o when we=0.
- Outputs are held stable for the whole state.
- Reset:
  - Asserting rst_ni low at any time forces IDLE immediately (asynchronously).
  - All outputs go to 0 except req_ready_o, which is 1 after reset.
  - All captured registers are cleared.
  - A write in progress is aborted: cache_we_o drops asynchronously, and no response is issued for the aborted request.
- req_valid_i while not ready is ignored; the requester must hold it.

Test Plan:
- Word store 0x11223344 @0x80000000, then LW @0x80000000 -> store: we pulse 1 cycle, data 0x11223344; load: rsp 2 cycles after accept, rdata 0x11223344, err 0.
- After the above, SB 0x80 @0x80000002 -> READ then WRITE, cache_w_data_o=0x11803344. Then LB @0x80000002 -> 0xFFFFFF80; LBU -> 0x00000080.
- SH 0xBEEF @0x80000002, then LH @0x80000002 -> write word 0xBEEF3344, LH 0xFFFFBEEF, LHU 0x0000BEEF. Then LB @0x80000001 -> 0x00000033.
- LW @0x80000002, SH @0x80000001, size=11 @0x80000000 -> each gives rsp_valid with err=1 and rdata=0 one cycle after accept; re and we stay 0 throughout.
- Back-to-back: req_valid_i held high with 3 loads -> ready low during READ/RESP, each accepted the cycle after RESP, responses in order.
- rst_ni pulsed low during the WRITE state of an SB -> cache_we_o drops to 0 immediately; no rsp_valid; req_ready_o=1 after release; next LW is serviced normally.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Byte/half/word load-store front end for a word-wide data cache;
//            sub-word stores are done as read-modify-write.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int READ_SWAP = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              cache_re_o,
    output logic [ADDR_W-1:0] cache_r_addr_o,
    input  logic [31:0]       cache_rdata_i,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_w_addr_o,
    output logic [31:0]       cache_w_data_o
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic              err_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;

    logic              accept;
    logic              req_err;
    logic [31:0]       rdata_lane;
    logic [31:0]       merged;
    logic [31:0]       load_val;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    // The cache read port returns offset 0 in the top byte; bring it to lane 0.
    generate
        if (READ_SWAP != 0) begin : g_swap
            assign rdata_lane = {cache_rdata_i[7:0],   cache_rdata_i[15:8],
                                 cache_rdata_i[23:16], cache_rdata_i[31:24]};
        end else begin : g_noswap
            assign rdata_lane = cache_rdata_i;
        end
    endgenerate

    assign accept = req_valid_i && (state_q == S_IDLE);

    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr_i[0];
            SZ_WORD: req_err = |req_addr_i[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        merged = word_q;
        if (size_q == SZ_BYTE) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        ld_byte  = word_q[{addr_q[1:0], 3'b000} +: 8];
        ld_half  = word_q[{addr_q[1], 4'b0000} +: 16];
        load_val = word_q;
        case (size_q)
            SZ_BYTE: load_val = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: load_val = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_val = word_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_ready_o    = 1'b0;
        cache_re_o     = 1'b0;
        cache_r_addr_o = '0;
        cache_we_o     = 1'b0;
        cache_w_addr_o = '0;
        cache_w_data_o = '0;
        rsp_valid_o    = 1'b0;
        rsp_err_o      = 1'b0;
        rsp_rdata_o    = '0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (req_we_i && (req_size_i == SZ_WORD)) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cache_re_o     = 1'b1;
                cache_r_addr_o = addr_q;
                state_d        = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                cache_we_o     = 1'b1;
                cache_w_addr_o = addr_q;
                cache_w_data_o = (size_q == SZ_WORD) ? wdata_q : merged;
                state_d        = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                rsp_rdata_o = (we_q || err_q) ? 32'b0 : load_val;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                size_q  <= req_size_i;
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                err_q   <= req_err;
                wdata_q <= req_wdata_i;
            end
            if (state_q == S_READ) begin
                word_q <= rdata_lane;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Scoreboard bench for mem_access_unit against a byte-array memory
//            model, with an emulated word-wide cache.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [1:0]  req_size = 2'b0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cache_re;
    logic [31:0] cache_r_addr;
    logic [31:0] cache_rdata;
    logic        cache_we;
    logic [31:0] cache_w_addr;
    logic [31:0] cache_w_data;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .READ_SWAP(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .cache_re_o     (cache_re),
        .cache_r_addr_o (cache_r_addr),
        .cache_rdata_i  (cache_rdata),
        .cache_we_o     (cache_we),
        .cache_w_addr_o (cache_w_addr),
        .cache_w_data_o (cache_w_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nreads;
        int          acc_cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t        expq[$];
    wr_t         wq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rd_seen = 0;
    logic [31:0] cur_addr = 32'b0;
    logic        cache_init = 1'b0;
    logic [7:0]  refmem   [0:63];
    logic [7:0]  init_img [0:63];
    logic [7:0]  cmem     [0:63];
    logic [7:0]  saved    [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    // Emulated cache: 64 bytes, read port returns offset 0 in bits [31:24].
    assign cache_rdata = {cmem[{cache_r_addr[5:2], 2'b00}], cmem[{cache_r_addr[5:2], 2'b01}],
                          cmem[{cache_r_addr[5:2], 2'b10}], cmem[{cache_r_addr[5:2], 2'b11}]};

    always @(posedge clk) begin
        if (cache_init) begin
            for (int i = 0; i < 64; i++) cmem[i] <= init_img[i];
        end else if (rst_n && cache_we) begin
            for (int k = 0; k < 4; k++) cmem[{cache_w_addr[5:2], 2'(k)}] <= cache_w_data[8*k +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_seen = 0;
                continue;
            end
            check("re_we_exclusive", 32'(cache_re & cache_we), 32'd0);
            if (!cache_re) check("r_addr_idle_zero", cache_r_addr, 32'd0);
            if (!cache_we) check("w_bus_idle_zero", cache_w_addr | cache_w_data, 32'd0);
            if (cache_re) begin
                rd_seen++;
                check("r_addr", cache_r_addr, cur_addr);
            end
            if (cache_we) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", cache_w_addr, cache_w_data);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("w_addr", cache_w_addr, w.addr);
                    check("w_data", cache_w_data, w.data);
                end
            end
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rdata %h err %0d expected none", rsp_rdata, rsp_err);
                end else begin
                    rsp_t e;
                    e = expq.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
                    check("read_cycles", 32'(rd_seen), 32'(e.nreads));
                end
                rd_seen = 0;
            end
        end
    endtask

    // Reference model computes the expectation, then the request is driven.
    // Entered and left just after a falling edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input bit keep, output int acc);
        rsp_t        e;
        wr_t         w;
        logic [31:0] v;
        bit          err;
        int          nb;
        int          off;
        int          wb;
        int          waits;
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        off = int'(addr[5:0]);
        nb = 1 << int'(size);
        e.rdata = 32'b0;
        e.err = err;
        e.lat = 1;
        e.nreads = 0;
        e.acc_cyc = 0;
        w.addr = addr;
        w.data = 32'b0;
        if (!err && !we) begin
            v = 32'b0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = refmem[off + i];
            if (nb == 1) v = uns ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            else if (nb == 2) v = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            e.rdata = v;
            e.lat = 2;
            e.nreads = 1;
        end else if (!err) begin
            for (int i = 0; i < nb; i++) refmem[off + i] = wdata[8*i +: 8];
            wb = off & ~3;
            for (int k = 0; k < 4; k++) w.data[8*k +: 8] = refmem[wb + k];
            e.lat = (nb == 4) ? 2 : 3;
            e.nreads = (nb == 4) ? 0 : 1;
        end
        req_valid = 1'b1;
        req_we = we;
        req_addr = addr;
        req_size = size;
        req_unsigned = uns;
        req_wdata = wdata;
        waits = 0;
        while (!req_ready) begin
            @(negedge clk);
            waits++;
            if (waits > 20) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got ready 0 for %0d cycles expected 1", waits);
                req_valid = 1'b0;
                acc = -1;
                return;
            end
        end
        @(posedge clk);
        #1;
        e.acc_cyc = cyc;
        acc = cyc;
        cur_addr = addr;
        expq.push_back(e);
        if (we && !err) wq.push_back(w);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    initial begin
        int a0, a1, a2, waits;
        bit we_r;
        logic [1:0] sz;
        logic [31:0] ad;
        for (int i = 0; i < 64; i++) begin
            init_img[i] = 8'($urandom);
            refmem[i] = init_img[i];
        end
        cache_init = 1'b1;
        fork
            monitor();
            begin
                #400000;
                $display("FAIL global_timeout: got no completion expected finish");
                $fatal(1, "timeout");
            end
        join_none
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        cache_init = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_re_we", 32'({cache_re, cache_we}), 32'd0);
        check("reset_rsp_data", rsp_rdata | 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 32'h8000_0000, 2'b10, 1'b0, 32'h1122_3344, 1'b0, a0);
        issue(1'b0, 32'h8000_0000, 2'b10, 1'b0, 32'h0,         1'b0, a0);
        issue(1'b1, 32'h8000_0002, 2'b00, 1'b0, 32'h0000_0080, 1'b0, a0);
        issue(1'b0, 32'h8000_0002, 2'b00, 1'b0, 32'h0,         1'b0, a0);
        issue(1'b0, 32'h8000_0002, 2'b00, 1'b1, 32'h0,         1'b0, a0);
        issue(1'b1, 32'h8000_0002, 2'b01, 1'b0, 32'h0000_BEEF, 1'b0, a0);
        issue(1'b0, 32'h8000_0002, 2'b01, 1'b0, 32'h0,         1'b0, a0);
        issue(1'b0, 32'h8000_0002, 2'b01, 1'b1, 32'h0,         1'b0, a0);
        issue(1'b0, 32'h8000_0001, 2'b00, 1'b0, 32'h0,         1'b0, a0);
        issue(1'b0, 32'h8000_0002, 2'b10, 1'b0, 32'h0,         1'b0, a0);
        issue(1'b1, 32'h8000_0001, 2'b01, 1'b0, 32'h1234,      1'b0, a0);
        issue(1'b0, 32'h8000_0000, 2'b11, 1'b0, 32'h0,         1'b0, a0);

        // Back-to-back loads with valid held high across the busy cycles.
        issue(1'b0, 32'h8000_0000, 2'b10, 1'b0, 32'h0, 1'b1, a0);
        issue(1'b0, 32'h8000_0003, 2'b00, 1'b0, 32'h0, 1'b1, a1);
        issue(1'b0, 32'h8000_0002, 2'b01, 1'b1, 32'h0, 1'b0, a2);
        check("b2b_gap1", 32'(a1 - a0), 32'd3);
        check("b2b_gap2", 32'(a2 - a1), 32'd3);

        // Reset asserted in the WRITE phase of a byte store aborts it.
        for (int i = 0; i < 64; i++) saved[i] = refmem[i];
        issue(1'b1, 32'h8000_0006, 2'b00, 1'b0, 32'h0000_005A, 1'b0, a0);
        waits = 0;
        while (!cache_we && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        check("abort_we_seen", 32'(cache_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we_drop", 32'(cache_we), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_rsp", 32'(rsp_valid), 32'd0);
        if (expq.size() > 0) void'(expq.pop_back());
        wq.delete();
        for (int i = 0; i < 64; i++) refmem[i] = saved[i];
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        issue(1'b0, 32'h8000_0004, 2'b10, 1'b0, 32'h0, 1'b0, a0);

        for (int n = 0; n < 200; n++) begin
            we_r = 1'($urandom);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ad = 32'h8000_0000 | 32'($urandom_range(0, 63));
            if (sz != 2'b11 && $urandom_range(0, 1) == 1) ad = ad & ~((32'd1 << sz) - 32'd1);
            issue(we_r, ad, sz, 1'($urandom), $urandom, (n != 199) && ($urandom_range(0, 1) == 1), a0);
        end

        waits = 0;
        while (expq.size() != 0 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("pending_responses", 32'(expq.size()), 32'd0);
        check("pending_writes", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
